regfile_scan: RTL

- Parametrised, clocked successor to the CPU's 32-entry register file.
- Two combinational read ports and one synchronous write port. Entry 0 is hardwired to zero.
- Synchronous active-low clear of every entry.
- On-board debug LED driver: either echoes the last write, or cycles through register contents at a divided rate.
- Sits between decode (read addresses) and write-back (write port). LEDs go to the board pins.

---
 rtl/regfile_scan.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_scan.sv
// Register file with two combinational read ports, one synchronous write port and a debug LED driver.
// Latency: reads are zero-cycle combinational; a write is visible on the read ports after its clock edge.
// Backpressure: none. A write is accepted on every enabled edge, and the LED scan runs free.
//
// Ports:
//   clk, rst_n                     - clock; synchronous active-low clear of all state
//   readRegister1/2, readData1/2   - combinational read ports; address 0 always reads zero
//   regWrite, writeRegister,
//   writeData                      - synchronous write port; writes to address 0 are dropped
//   ledMode                        - 0: echo low bits of the last write-back, 1: scan register contents
//   regLED                         - active-low debug LEDs (0 = lit)
//   ledScanIdx                     - register index currently shown in scan mode
//
// Build option: define REGFILE_BYPASS_EN to forward the write port onto the read ports
// (and onto the scanned LED value) during the write cycle. When it is undefined,
// no forwarding logic is built.
//
// LED_W must not exceed SIZE, and SCAN_DIV must be at least 1.

module regfile_scan #(
    parameter int SIZE     = 32,
    parameter int ADDR_W   = 5,
    parameter int LED_W    = 4,
    parameter int SCAN_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] readRegister1,
    input  logic [ADDR_W-1:0] readRegister2,
    output logic [SIZE-1:0]   readData1,
    output logic [SIZE-1:0]   readData2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeRegister,
    input  logic [SIZE-1:0]   writeData,
    input  logic              ledMode,
    output logic [LED_W-1:0]  regLED,
    output logic [ADDR_W-1:0] ledScanIdx
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One bit is the minimum counter width, and it keeps SCAN_DIV == 1 legal.
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [SIZE-1:0]   regs [DEPTH];
    logic [LED_W-1:0]  last_wr;
    logic [ADDR_W-1:0] scan_idx;
    logic [DIV_W-1:0]  div_cnt;
    logic              mode_q;

    logic              wr_en;
    logic              mode_chg;
    logic [SIZE-1:0]   stored1;
    logic [SIZE-1:0]   stored2;
    logic [LED_W-1:0]  scan_led;

    // A write is real only when it targets a non-zero address. Address 0 has no
    // writable storage behind it.
    assign wr_en    = regWrite && (writeRegister != '0);
    assign mode_chg = (ledMode != mode_q);

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[writeRegister] <= writeData;
        end
    end

    // ------------------------------------------------------------------
    // LED state: last write-back echo, scan divider and scan index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_wr  <= '0;
            scan_idx <= '0;
            div_cnt  <= '0;
            mode_q   <= 1'b0;
        end else begin
            mode_q <= ledMode;

            // The echo follows the write-back bus, including writes to r0.
            if (regWrite) begin
                last_wr <= writeData[LED_W-1:0];
            end

            // A mode edge restarts the dwell and keeps the index. Mode 0 freezes both.
            if (mode_chg) begin
                div_cnt <= '0;
            end else if (ledMode) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt  <= '0;
                    scan_idx <= scan_idx + ADDR_W'(1);  // DEPTH is a power of two, so this wraps naturally
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports and scanned LED value
    // ------------------------------------------------------------------
    always_comb begin
        stored1  = (readRegister1 == '0) ? '0 : regs[readRegister1];
        stored2  = (readRegister2 == '0) ? '0 : regs[readRegister2];
        scan_led = (scan_idx == '0) ? '0 : regs[scan_idx][LED_W-1:0];

`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes address 0, so r0 is never forwarded.
        readData1 = (wr_en && (readRegister1 == writeRegister)) ? writeData : stored1;
        readData2 = (wr_en && (readRegister2 == writeRegister)) ? writeData : stored2;
        if (wr_en && (scan_idx == writeRegister)) begin
            scan_led = writeData[LED_W-1:0];
        end
`else
        readData1 = stored1;
        readData2 = stored2;
`endif
    end

    assign regLED     = ledMode ? ~scan_led : ~last_wr;
    assign ledScanIdx = scan_idx;

endmodule
